// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one bit per cycle.
// Optional build macro MDU_EARLY_OUT_EN: multiply exits ITER once the remaining multiplier bits are zero.
`default_nettype none

module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;   // product sign for MUL, quotient sign for DIV
  logic               neg_r;
  logic [2*WIDTH-1:0] acc;     // MUL: product; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand;   // MUL: shifted multiplicand; DIV: divisor in low half
  logic [WIDTH-1:0]   mplr;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf, zero_mul;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_fix;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               early_exit;

  always_comb begin
    a_mag    = (op_i[0] && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag    = (op_i[0] && b_i[WIDTH-1]) ? -b_i : b_i;
    div_zero = op_i[1] && (b_i == '0);
    div_ovf  = (op_i == 2'b11) && (a_i == MOST_NEG) && (b_i == '1);

    mul_next = acc + (mplr[0] ? mcand : '0);

    // Restoring step: shift next dividend bit into the remainder, keep the difference if non-negative.
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, mcand[WIDTH-1:0]};
    div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};

    mul_fix  = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
    zero_mul   = !op_i[1] && (b_mag == '0);
    early_exit = !is_div && (mplr[WIDTH-1:1] == '0);
`else
    zero_mul   = 1'b0;
    early_exit = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            if (div_zero) begin
              hi_o   <= a_i;
              lo_o   <= '1;
              done_o <= 1'b1;
              state  <= DONE;
            end else if (div_ovf) begin
              hi_o   <= '0;
              lo_o   <= a_i;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              is_div <= op_i[1];
              neg_q  <= op_i[0] & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              neg_r  <= op_i[0] & a_i[WIDTH-1];
              cnt    <= CNT_W'(WIDTH);
              busy_o <= 1'b1;
              mplr   <= b_mag;
              if (op_i[1]) begin
                acc   <= {{WIDTH{1'b0}}, a_mag};
                mcand <= {{WIDTH{1'b0}}, b_mag};
              end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, a_mag};
              end
              state <= zero_mul ? FIX : ITER;
            end
          end
        end
        ITER: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
              acc <= div_next;
            end else begin
              acc   <= mul_next;
              mcand <= mcand << 1;
              mplr  <= mplr >> 1;
            end
            if (cnt == CNT_W'(1) || early_exit) begin
              state <= FIX;
              if (early_exit) cnt <= '0;
            end
          end
        end
        FIX: begin
          busy_o <= 1'b0;
          if (flush_i) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              hi_o <= r_fix;
              lo_o <= q_fix;
            end else begin
              hi_o <= mul_fix[2*WIDTH-1:WIDTH];
              lo_o <= mul_fix[WIDTH-1:0];
            end
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;  // DONE: result already committed, flush has no effect
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed self-checking bench for mdu_iterative (WIDTH=32).
`default_nettype none

module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT1 = 4, BUSY1 = 3, LAT6A = 4, LAT6B = 2;
`else
  localparam int LAT1 = 34, BUSY1 = 33, LAT6A = 34, LAT6B = 34;
`endif

  mdu_iterative #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; lat counts cycles from T (first negedge = T+1).
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cyc++;
    end
    if (lat == 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cyc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy_cyc);
    @(posedge clk); #1;
  endtask

  int lat, bc, dones;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MULTU latency and busy window
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bc);
    check("multu_lat", 64'(lat), 64'(LAT1));
    check("multu_busy", 64'(bc), 64'(BUSY1));
    check("multu_res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    run_op(2'b01, -32'sd3, 32'd5, lat, bc);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, bc);
    check("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(2'b11, -32'sd7, 32'd2, lat, bc);
    check("div_lat", 64'(lat), 64'd34);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, -32'sd2, lat, bc);
    check("div_negb", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd7, lat, bc);
    check("divu", {hi, lo}, 64'h0000_0002_0000_000E);

    // special cases complete at T+1
    run_op(2'b10, 32'd100, 32'd0, lat, bc);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_res", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    check("ovf_lat", 64'(lat), 64'd1);
    check("ovf_res", {hi, lo}, 64'h0000_0000_8000_0000);

    // flush mid-divide keeps the previous result
    run_op(2'b00, 32'h8000_0001, 32'd2, lat, bc);
    check("prior_res", {hi, lo}, 64'h0000_0001_0000_0002);
    op = 2'b10; a = 32'd50; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", 64'(busy), 64'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_keep", {hi, lo}, 64'h0000_0001_0000_0002);

    // start while busy is ignored
    @(posedge clk); #1;
    op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op = 2'b10; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (60) begin @(negedge clk); if (done) dones++; end
    check("ignore_one_done", 64'(dones), 64'd1);
    check("ignore_res", {hi, lo}, 64'd42);

    // reset mid-multiply, new op accepted the cycle after
    @(posedge clk); #1;
    op = 2'b01; a = 32'd3; b = -32'sd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op = 2'b01; a = 32'd3; b = -32'sd4; start = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("after_rst_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF4);
    @(posedge clk); #1;

    // small multiplier / zero multiplier latency
    run_op(2'b00, 32'd7, 32'd3, lat, bc);
    check("mul73_lat", 64'(lat), 64'(LAT6A));
    check("mul73_res", {hi, lo}, 64'd21);
    run_op(2'b00, 32'd7, 32'd0, lat, bc);
    check("mul0_lat", 64'(lat), 64'(LAT6B));
    check("mul0_res", {hi, lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
